// File: rtl/drp_pkg.sv
// Shared definitions for the DRP ADC responder: FSM encoding, register-space
// map and counter widths.
package drp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } drp_state_t;

   localparam logic [6:0]  STATUS_MAX       = 7'h3F;
   localparam logic [6:0]  CONFIG_BASE      = 7'h40;
   localparam logic [6:0]  AUX_BASE_DEFAULT = 7'h10;
   localparam int unsigned DROP_W           = 8;

   function automatic logic is_config(input logic [6:0] addr);
      return (addr > STATUS_MAX) && (addr >= CONFIG_BASE);
   endfunction

endpackage

// File: rtl/drp_regfile.sv
// 128x16 register space with a DRP write port, a sample write port and an
// asynchronous read port.
module drp_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic        drp_we,
   input  logic [6:0]  drp_addr,
   input  logic [15:0] drp_wdata,
   input  logic        smp_we,
   input  logic [6:0]  smp_addr,
   input  logic [15:0] smp_wdata,
   input  logic [6:0]  rd_addr,
   output logic [15:0] rd_data
);

   logic [15:0] mem [128];

   // DRP writes only reach config space and samples only status space, so the
   // two ports never collide; the sample port is ordered last regardless.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 128; i++) mem[i] <= '0;
      end else begin
         if (drp_we) mem[drp_addr] <= drp_wdata;
         if (smp_we) mem[smp_addr] <= smp_wdata;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/drp_adc_responder.sv
// DRP slave modelling an ADC: fixed-latency register access, injected aux
// conversion results with end-of-conversion strobes, and a dropped-request counter.
module drp_adc_responder
   import drp_pkg::*;
#(
   parameter int unsigned READ_LAT = 4,
   parameter logic [6:0]  AUX_BASE = AUX_BASE_DEFAULT
) (
   input  logic              CLK100MHZ,
   input  logic              reset_in,
   input  logic              den_in,
   input  logic              dwe_in,
   input  logic [6:0]        daddr_in,
   input  logic [15:0]       di_in,
   output logic [15:0]       do_out,
   output logic              drdy_out,
   output logic              busy_out,
   input  logic              sample_valid,
   input  logic [3:0]        sample_ch,
   input  logic [15:0]       sample_data,
   output logic              eoc_out,
   output logic [4:0]        channel_out,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam logic [3:0] WAIT_LOAD = (READ_LAT > 1) ? 4'(READ_LAT - 2) : 4'd0;

   drp_state_t  state, next_state;
   logic [3:0]  wait_cnt;
   logic [6:0]  addr_q;
   logic        we_q;
   logic [15:0] wdata_q;
   logic [15:0] rdata_q;
   logic [15:0] rd_data;
   logic        accept;
   logic        commit;
   logic [6:0]  smp_addr;

   assign accept   = den_in && (state == ST_IDLE);
   assign commit   = (state == ST_RESP) && we_q && is_config(addr_q);
   assign smp_addr = AUX_BASE + {3'b000, sample_ch};

   drp_regfile u_regfile (
      .clk       (CLK100MHZ),
      .rst       (reset_in),
      .drp_we    (commit),
      .drp_addr  (addr_q),
      .drp_wdata (wdata_q),
      .smp_we    (sample_valid),
      .smp_addr  (smp_addr),
      .smp_wdata (sample_data),
      .rd_addr   (daddr_in),
      .rd_data   (rd_data)
   );

   always_ff @(posedge CLK100MHZ or posedge reset_in) begin
      if (reset_in) state <= ST_IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE: if (den_in) next_state = (READ_LAT == 1) ? ST_RESP : ST_WAIT;
         ST_WAIT: if (wait_cnt == 4'd0) next_state = ST_RESP;
         ST_RESP: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Read data is captured at the accepting edge, so a sample landing on the
   // same edge is not visible to this transaction.
   always_ff @(posedge CLK100MHZ or posedge reset_in) begin
      if (reset_in) begin
         wait_cnt <= '0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else if (accept) begin
         wait_cnt <= WAIT_LOAD;
         addr_q   <= daddr_in;
         we_q     <= dwe_in;
         wdata_q  <= di_in;
         rdata_q  <= rd_data;
      end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
         wait_cnt <= wait_cnt - 4'd1;
      end
   end

   always_ff @(posedge CLK100MHZ or posedge reset_in) begin
      if (reset_in) begin
         drop_cnt <= '0;
      end else if (den_in && (state != ST_IDLE) && (drop_cnt != '1)) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end

   always_ff @(posedge CLK100MHZ or posedge reset_in) begin
      if (reset_in) begin
         eoc_out     <= 1'b0;
         channel_out <= '0;
      end else begin
         eoc_out <= sample_valid;
         if (sample_valid) channel_out <= {1'b1, sample_ch};
      end
   end

   assign drdy_out = (state == ST_RESP);
   assign busy_out = (state != ST_IDLE);
   assign do_out   = ((state == ST_RESP) && !we_q) ? rdata_q : '0;

endmodule

// File: tb/tb_drp_adc_responder.sv
// Scoreboard bench for drp_adc_responder: a READ_LAT=4 instance (a) and a
// READ_LAT=1 instance (b) sharing clock and reset.
module tb_drp_adc_responder;

   typedef struct {
      logic [15:0] data;
      int unsigned due;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   exp_t qa[$];
   exp_t qb[$];

   logic        a_den, a_we, a_sv;
   logic [6:0]  a_addr;
   logic [15:0] a_di, a_sd, a_do;
   logic [3:0]  a_sch;
   logic        a_drdy, a_busy, a_eoc;
   logic [4:0]  a_chan;
   logic [7:0]  a_drop;

   logic        b_den, b_we, b_sv;
   logic [6:0]  b_addr;
   logic [15:0] b_di, b_sd, b_do;
   logic [3:0]  b_sch;
   logic        b_drdy, b_busy, b_eoc;
   logic [4:0]  b_chan;
   logic [7:0]  b_drop;

   drp_adc_responder #(.READ_LAT(4), .AUX_BASE(7'h10)) dut_a (
      .CLK100MHZ(clk), .reset_in(rst), .den_in(a_den), .dwe_in(a_we),
      .daddr_in(a_addr), .di_in(a_di), .do_out(a_do), .drdy_out(a_drdy),
      .busy_out(a_busy), .sample_valid(a_sv), .sample_ch(a_sch),
      .sample_data(a_sd), .eoc_out(a_eoc), .channel_out(a_chan), .drop_cnt(a_drop)
   );

   drp_adc_responder #(.READ_LAT(1), .AUX_BASE(7'h10)) dut_b (
      .CLK100MHZ(clk), .reset_in(rst), .den_in(b_den), .dwe_in(b_we),
      .daddr_in(b_addr), .di_in(b_di), .do_out(b_do), .drdy_out(b_drdy),
      .busy_out(b_busy), .sample_valid(b_sv), .sample_ch(b_sch),
      .sample_data(b_sd), .eoc_out(b_eoc), .channel_out(b_chan), .drop_cnt(b_drop)
   );

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (!rst) begin
         checks++;
         if (a_drdy) begin
            if (qa.size() == 0) begin
               failures++;
               $display("FAIL a_unexpected_drdy cycle=%0d do_out=%h required no drdy", cyc, a_do);
            end else begin
               e = qa.pop_front();
               if (a_do !== e.data || cyc != e.due) begin
                  failures++;
                  $display("FAIL a_response do_out=%h cycle=%0d required do_out=%h cycle=%0d",
                           a_do, cyc, e.data, e.due);
               end
            end
         end else if (a_do !== 16'h0000) begin
            failures++;
            $display("FAIL a_do_idle do_out=%h required 0000", a_do);
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (!rst) begin
         checks++;
         if (b_drdy) begin
            if (qb.size() == 0) begin
               failures++;
               $display("FAIL b_unexpected_drdy cycle=%0d do_out=%h required no drdy", cyc, b_do);
            end else begin
               e = qb.pop_front();
               if (b_do !== e.data || cyc != e.due) begin
                  failures++;
                  $display("FAIL b_response do_out=%h cycle=%0d required do_out=%h cycle=%0d",
                           b_do, cyc, e.data, e.due);
               end
            end
         end else if (b_do !== 16'h0000) begin
            failures++;
            $display("FAIL b_do_idle do_out=%h required 0000", b_do);
         end
      end
   end

   task automatic a_issue(input logic [6:0] addr, input logic we, input logic [15:0] d,
                          input logic [15:0] exp_data);
      @(negedge clk);
      a_den = 1'b1; a_we = we; a_addr = addr; a_di = d;
      qa.push_back('{exp_data, cyc + 4});
      @(negedge clk);
      a_den = 1'b0; a_we = 1'b0;
   endtask

   task automatic b_issue(input logic [6:0] addr, input logic [15:0] exp_data);
      @(negedge clk);
      b_den = 1'b1; b_we = 1'b0; b_addr = addr;
      qb.push_back('{exp_data, cyc + 1});
      @(negedge clk);
      b_den = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 50 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         failures++;
         $display("FAIL wait_done pending a=%0d b=%0d required 0 0", qa.size(), qb.size());
      end
      @(negedge clk);
   endtask

   task automatic a_sample(input logic [3:0] ch, input logic [15:0] d);
      @(negedge clk);
      a_sv = 1'b1; a_sch = ch; a_sd = d;
      @(negedge clk);
      a_sv = 1'b0;
      checks++;
      if (a_eoc !== 1'b1 || a_chan !== {1'b1, ch}) begin
         failures++;
         $display("FAIL a_sample_eoc eoc=%b chan=%h required eoc=1 chan=%h", a_eoc, a_chan, {1'b1, ch});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_den = 0; a_we = 0; a_addr = '0; a_di = '0; a_sv = 0; a_sch = '0; a_sd = '0;
      b_den = 0; b_we = 0; b_addr = '0; b_di = '0; b_sv = 0; b_sch = '0; b_sd = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({a_do, a_drdy, a_busy, a_eoc, a_chan, a_drop} !== '0 ||
          {b_do, b_drdy, b_busy, b_eoc, b_chan, b_drop} !== '0) begin
         failures++;
         $display("FAIL reset_outputs a=%h/%b/%b/%b/%h/%h b=%h/%b/%b/%b/%h/%h required all zero",
                  a_do, a_drdy, a_busy, a_eoc, a_chan, a_drop, b_do, b_drdy, b_busy, b_eoc, b_chan, b_drop);
      end
      // first den on the edge right after release must be accepted
      rst = 1'b0;
      a_den = 1'b1; a_addr = 7'h40;
      qa.push_back('{16'h0000, cyc + 4});
      @(negedge clk);
      a_den = 1'b0;
      wait_done();
   endtask

   task automatic test_sample_read();
      a_sample(4'd6, 16'hA5A0);
      @(negedge clk);
      checks++;
      if (a_eoc !== 1'b0 || a_chan !== 5'h16) begin
         failures++;
         $display("FAIL eoc_single eoc=%b chan=%h required eoc=0 chan=16", a_eoc, a_chan);
      end
      a_issue(7'h16, 1'b0, 16'h0, 16'hA5A0);
      checks++;
      if (a_busy !== 1'b1) begin
         failures++;
         $display("FAIL busy_after_accept busy=%b required 1", a_busy);
      end
      wait_done();
      checks++;
      if (a_busy !== 1'b0) begin
         failures++;
         $display("FAIL busy_after_done busy=%b required 0", a_busy);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      a_sv = 1'b1; a_sch = 4'd3; a_sd = 16'h3330;
      @(negedge clk);
      a_sch = 4'd4; a_sd = 16'h4440;
      checks++;
      if (a_eoc !== 1'b1 || a_chan !== 5'h13) begin
         failures++;
         $display("FAIL b2b_first eoc=%b chan=%h required eoc=1 chan=13", a_eoc, a_chan);
      end
      @(negedge clk);
      a_sv = 1'b0;
      checks++;
      if (a_eoc !== 1'b1 || a_chan !== 5'h14) begin
         failures++;
         $display("FAIL b2b_second eoc=%b chan=%h required eoc=1 chan=14", a_eoc, a_chan);
      end
      @(negedge clk);
      checks++;
      if (a_eoc !== 1'b0 || a_chan !== 5'h14) begin
         failures++;
         $display("FAIL b2b_end eoc=%b chan=%h required eoc=0 chan=14", a_eoc, a_chan);
      end
      a_issue(7'h13, 1'b0, 16'h0, 16'h3330);
      wait_done();
      a_issue(7'h14, 1'b0, 16'h0, 16'h4440);
      wait_done();
   endtask

   task automatic test_config_write();
      a_issue(7'h41, 1'b1, 16'h1234, 16'h0000);
      wait_done();
      a_issue(7'h41, 1'b0, 16'h0, 16'h1234);
      wait_done();
      a_issue(7'h7F, 1'b1, 16'hCAFE, 16'h0000);
      wait_done();
      a_issue(7'h7F, 1'b0, 16'h0, 16'hCAFE);
      wait_done();
      a_issue(7'h16, 1'b1, 16'hFFFF, 16'h0000);
      wait_done();
      a_issue(7'h16, 1'b0, 16'h0, 16'hA5A0);
      wait_done();
   endtask

   task automatic test_drop();
      logic [7:0] d0;
      d0 = a_drop;
      @(negedge clk);
      a_den = 1'b1; a_we = 1'b0; a_addr = 7'h41;
      qa.push_back('{16'h1234, cyc + 4});
      @(negedge clk); a_den = 1'b0;
      @(negedge clk); a_den = 1'b1;
      @(negedge clk); a_den = 1'b0;
      @(negedge clk); a_den = 1'b1;
      @(negedge clk); a_den = 1'b0;
      wait_done();
      repeat (4) @(negedge clk);
      checks++;
      if (a_drop !== d0 + 8'd2) begin
         failures++;
         $display("FAIL drop_count drop_cnt=%h required %h", a_drop, d0 + 8'd2);
      end
   endtask

   task automatic test_same_edge();
      a_sample(4'd7, 16'h1000);
      @(negedge clk);
      a_sv = 1'b1; a_sch = 4'd7; a_sd = 16'h8000;
      a_den = 1'b1; a_we = 1'b0; a_addr = 7'h17;
      qa.push_back('{16'h1000, cyc + 4});
      @(negedge clk);
      a_sv = 1'b0; a_den = 1'b0;
      wait_done();
      a_issue(7'h17, 1'b0, 16'h0, 16'h8000);
      wait_done();
   endtask

   task automatic test_reset_mid();
      a_issue(7'h40, 1'b1, 16'hBEEF, 16'h0000);
      @(negedge clk);
      rst = 1'b1;
      qa.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (a_chan !== 5'h00 || a_drop !== 8'h00) begin
         failures++;
         $display("FAIL reset_mid_state chan=%h drop=%h required 00 00", a_chan, a_drop);
      end
      repeat (10) @(negedge clk);
      a_issue(7'h40, 1'b0, 16'h0, 16'h0000);
      wait_done();
      a_issue(7'h16, 1'b0, 16'h0, 16'h0000);
      wait_done();
   endtask

   task automatic test_lat1();
      logic [7:0]  d0;
      int unsigned c0;
      @(negedge clk);
      b_sv = 1'b1; b_sch = 4'd0; b_sd = 16'h0F00;
      @(negedge clk);
      b_sv = 1'b0;
      checks++;
      if (b_eoc !== 1'b1 || b_chan !== 5'h10) begin
         failures++;
         $display("FAIL b_sample_eoc eoc=%b chan=%h required eoc=1 chan=10", b_eoc, b_chan);
      end
      b_issue(7'h10, 16'h0F00);
      wait_done();
      // continuous den: RESP alternates with IDLE, so every second request drops
      d0 = b_drop;
      @(negedge clk);
      c0 = cyc;
      for (int j = 0; j < 300; j++) qb.push_back('{16'h0F00, c0 + 1 + 2 * j});
      b_den = 1'b1; b_addr = 7'h10;
      repeat (600) @(negedge clk);
      b_den = 1'b0;
      wait_done();
      checks++;
      if (b_drop !== 8'hFF || d0 !== 8'h00) begin
         failures++;
         $display("FAIL drop_saturate drop_cnt=%h start=%h required FF from 00", b_drop, d0);
      end
   endtask

   initial begin
      test_reset();
      test_sample_read();
      test_back_to_back();
      test_config_write();
      test_drop();
      test_same_edge();
      test_reset_mid();
      test_lat1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout time=%0t required finish before 200000", $time);
      $fatal(1, "timeout");
   end

endmodule
